// File: rtl/l1_data_ldst_pkg.sv
// Shared definitions for the L1 data load/store sequencing stage:
// access order codes, sequencer states and byte-lane mask constants.
package l1_data_ldst_pkg;

  localparam logic [1:0] ORD_BYTE = 2'd0;
  localparam logic [1:0] ORD_HALF = 2'd1;
  localparam logic [1:0] ORD_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Lane bit 3 is byte offset 0 (big-endian lane order)
  localparam logic [3:0] MASK_BYTE0   = 4'b1000;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

endpackage

// File: rtl/l1_data_ldst_format.sv
// Combinational formatting: request-side lane mask, store replication and
// alignment fault; response-side load lane extraction and extension.
module l1_data_ldst_format
  import l1_data_ldst_pkg::*;
(
  input  logic [1:0]  req_order,
  input  logic [1:0]  req_offset,
  input  logic [31:0] req_data,
  output logic [3:0]  req_mask,
  output logic [31:0] req_store,
  output logic        req_fault,
  input  logic [1:0]  rsp_order,
  input  logic [1:0]  rsp_offset,
  input  logic        rsp_signed,
  input  logic [31:0] rsp_word,
  output logic [31:0] rsp_result
);

  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  always_comb begin
    req_mask  = MASK_WORD;
    req_store = req_data;
    req_fault = 1'b0;
    case (req_order)
      ORD_BYTE: begin
        req_mask  = MASK_BYTE0 >> req_offset;
        req_store = {4{req_data[7:0]}};
      end
      ORD_HALF: begin
        req_mask  = req_offset[1] ? MASK_HALF_LO : MASK_HALF_HI;
        req_store = {2{req_data[15:0]}};
        req_fault = req_offset[0];
      end
      ORD_WORD: req_fault = (req_offset != 2'b00);
      default:  req_fault = 1'b1;
    endcase
  end

  always_comb begin
    rsp_byte = rsp_word[31:24];
    case (rsp_offset)
      2'd1:    rsp_byte = rsp_word[23:16];
      2'd2:    rsp_byte = rsp_word[15:8];
      2'd3:    rsp_byte = rsp_word[7:0];
      default: rsp_byte = rsp_word[31:24];
    endcase
    rsp_half = rsp_offset[1] ? rsp_word[15:0] : rsp_word[31:16];
    case (rsp_order)
      ORD_BYTE: rsp_result = {{24{rsp_signed & rsp_byte[7]}}, rsp_byte};
      ORD_HALF: rsp_result = {{16{rsp_signed & rsp_half[15]}}, rsp_half};
      default:  rsp_result = rsp_word;
    endcase
  end

endmodule

// File: rtl/l1_data_ldst_unit.sv
// Load/store sequencer in front of the L1 data cache: accepts one operation,
// issues a registered cache request, waits for the response, hands off to writeback.
module l1_data_ldst_unit
  import l1_data_ldst_pkg::*;
#(
  parameter int P_DEST_W = 5
) (
  input  logic                iCLOCK,
  input  logic                iRESET,
  input  logic                iRESET_SYNC,
  input  logic                iEXE_VALID,
  output logic                oEXE_BUSY,
  input  logic                iEXE_RW,
  input  logic [1:0]          iEXE_ORDER,
  input  logic                iEXE_SIGNED,
  input  logic [31:0]         iEXE_ADDR,
  input  logic [31:0]         iEXE_DATA,
  input  logic [P_DEST_W-1:0] iEXE_DEST,
  output logic                oLDST_REQ,
  input  logic                iLDST_BUSY,
  output logic [1:0]          oLDST_ORDER,
  output logic [3:0]          oLDST_MASK,
  output logic                oLDST_RW,
  output logic [31:0]         oLDST_ADDR,
  output logic [31:0]         oLDST_DATA,
  input  logic                iLDST_VALID,
  input  logic [31:0]         iLDST_DATA,
  output logic                oWB_VALID,
  input  logic                iWB_BUSY,
  output logic                oWB_WE,
  output logic [P_DEST_W-1:0] oWB_DEST,
  output logic [31:0]         oWB_DATA,
  output logic                oWB_FAULT
);

  state_t state, state_next;
  logic accept, handshake, response, retire;

  logic [3:0]  mask_p0;
  logic [31:0] store_p0;
  logic        fault_p0;

  logic                rw_p1, signed_p1;
  logic [1:0]          order_p1;
  logic [31:0]         addr_p1, data_p1, load_p1;
  logic [3:0]          mask_p1;
  logic [P_DEST_W-1:0] dest_p1;

  logic [31:0] wb_data_p2;
  logic        wb_we_p2, wb_fault_p2;

  assign accept    = (state == ST_IDLE) && iEXE_VALID;
  assign handshake = (state == ST_REQ)  && !iLDST_BUSY;
  assign response  = (state == ST_WAIT) && iLDST_VALID;
  assign retire    = (state == ST_DONE) && !iWB_BUSY;

  // Stage p0: format the incoming operation; p1 fields format the response
  l1_data_ldst_format u_format (
    .req_order  (iEXE_ORDER),
    .req_offset (iEXE_ADDR[1:0]),
    .req_data   (iEXE_DATA),
    .req_mask   (mask_p0),
    .req_store  (store_p0),
    .req_fault  (fault_p0),
    .rsp_order  (order_p1),
    .rsp_offset (addr_p1[1:0]),
    .rsp_signed (signed_p1),
    .rsp_word   (iLDST_DATA),
    .rsp_result (load_p1)
  );

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET)           state <= ST_IDLE;
    else if (iRESET_SYNC) state <= ST_IDLE;
    else                  state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = fault_p0 ? ST_DONE : ST_REQ;
      ST_REQ:  if (handshake) state_next = ST_WAIT;
      ST_WAIT: if (response)  state_next = ST_DONE;
      ST_DONE: if (retire)    state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oEXE_BUSY = (state != ST_IDLE);
    oLDST_REQ = (state == ST_REQ);
    oWB_VALID = (state == ST_DONE);
  end

  // Stage p1: request fields held for the cache; stage p2: writeback result
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET || iRESET_SYNC) begin
      rw_p1       <= 1'b0;
      signed_p1   <= 1'b0;
      order_p1    <= 2'd0;
      addr_p1     <= 32'd0;
      data_p1     <= 32'd0;
      mask_p1     <= 4'd0;
      dest_p1     <= '0;
      wb_data_p2  <= 32'd0;
      wb_we_p2    <= 1'b0;
      wb_fault_p2 <= 1'b0;
    end else begin
      if (accept) begin
        rw_p1       <= iEXE_RW;
        signed_p1   <= iEXE_SIGNED;
        order_p1    <= iEXE_ORDER;
        addr_p1     <= iEXE_ADDR;
        data_p1     <= store_p0;
        mask_p1     <= mask_p0;
        dest_p1     <= iEXE_DEST;
        wb_data_p2  <= 32'd0;
        wb_we_p2    <= 1'b0;
        wb_fault_p2 <= fault_p0;
      end
      if (response) begin
        wb_data_p2 <= rw_p1 ? 32'd0 : load_p1;
        wb_we_p2   <= !rw_p1;
      end
      if (retire) begin
        wb_data_p2  <= 32'd0;
        wb_we_p2    <= 1'b0;
        wb_fault_p2 <= 1'b0;
      end
    end
  end

  assign oLDST_ORDER = order_p1;
  assign oLDST_MASK  = mask_p1;
  assign oLDST_RW    = rw_p1;
  assign oLDST_ADDR  = {addr_p1[31:2], 2'b00};
  assign oLDST_DATA  = data_p1;
  assign oWB_WE      = wb_we_p2;
  assign oWB_DEST    = dest_p1;
  assign oWB_DATA    = wb_data_p2;
  assign oWB_FAULT   = wb_fault_p2;

endmodule

// File: doc/l1_data_ldst_unit.md
# l1_data_ldst_unit

Load/store sequencing stage directly upstream of the L1 data cache. Accepts one memory operation at a time from execute, checks alignment, builds the byte-lane mask and lane-replicated store data, and drives the cache's LDST request port. It then waits for the cache's valid response and returns a sign- or zero-extended result to writeback. Misaligned accesses fault locally and never reach the cache.

## Interface
Parameters:
- P_DEST_W, 5, width of destination register tag

Ports:
- iCLOCK  in  1  clock
- iRESET  in  1  asynchronous active-high reset
- iRESET_SYNC  in  1  synchronous flush; same effect as reset
- iEXE_VALID  in  1  execute presents an operation
- oEXE_BUSY  out  1  unit cannot accept (state != IDLE)
- iEXE_RW  in  1  0=load, 1=store
- iEXE_ORDER  in  2  0=byte, 1=half, 2=word (3 reserved, treated as fault)
- iEXE_SIGNED  in  1  load sign-extends when 1
- iEXE_ADDR  in  32  byte address
- iEXE_DATA  in  32  store data, right-justified
- iEXE_DEST  in  P_DEST_W  load destination tag
- oLDST_REQ  out  1  request to cache
- iLDST_BUSY  in  1  cache cannot accept this cycle
- oLDST_ORDER  out  2  registered order
- oLDST_MASK  out  4  byte-lane enables, bit3 = byte offset 0 (big-endian)
- oLDST_RW  out  1  0=load, 1=store
- oLDST_ADDR  out  32  {addr[31:2], 2'b00}
- oLDST_DATA  out  32  lane-replicated store data
- iLDST_VALID  in  1  cache response (loads and stores)
- iLDST_DATA  in  32  cache read word
- oWB_VALID  out  1  result available
- iWB_BUSY  in  1  writeback stalls
- oWB_WE  out  1  register write enable (load, no fault)
- oWB_DEST  out  P_DEST_W  destination tag
- oWB_DATA  out  32  formatted load data (0 for stores/faults)
- oWB_FAULT  out  1  misalignment fault

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on iEXE_VALID, latch all iEXE_* fields, compute mask/data/fault. Fault (half with addr[0]=1, word with addr[1:0]!=0, order 3) -> DONE with oWB_FAULT=1, oWB_WE=0. Else -> REQ.
- REQ: oLDST_REQ=1, all oLDST_* stable. Cycle with !iLDST_BUSY is the handshake -> WAIT.
- WAIT: on iLDST_VALID capture formatted data -> DONE. iLDST_VALID in any other state ignored.
- DONE: oWB_VALID=1 held with stable fields until !iWB_BUSY, then IDLE.
- Mask: byte -> 4'b1000>>addr[1:0]; half -> addr[1]?4'b0011:4'b1100; word -> 4'b1111.
- Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load extract: byte offset k -> iLDST_DATA[31-8k -: 8]; half offset 0 -> [31:16], 2 -> [15:0]; extended to 32 bits per iEXE_SIGNED.

## Timing
- Reset (async iRESET or iRESET_SYNC): state IDLE; oEXE_BUSY, oLDST_REQ, oWB_VALID, oWB_WE, oWB_FAULT = 0; all data/addr/mask/order/dest registers = 0.
- Accept at cycle 0; oLDST_REQ earliest cycle 1; with zero busy and 1-cycle cache hit, iLDST_VALID cycle 2, oWB_VALID cycle 3. Fault: oWB_VALID cycle 1.
- oEXE_BUSY = (state != IDLE), combinational from state; new op accepted the cycle after DONE retires.
- oLDST_* outputs registered; never change while oLDST_REQ high.
- iRESET_SYNC mid-REQ/WAIT drops request immediately; a later stale iLDST_VALID is ignored in IDLE.
- iLDST_VALID coincident with DONE retirement ignored.

## Structure
- Package l1_data_ldst_pkg: order codes (BYTE/HALF/WORD), state enum, mask constants.
- Sub-module l1_data_ldst_format: combinational mask generation, store replication, load extraction/extension, fault detect; instantiated once.

## Test plan
- Word load addr 0x0000_1004, cache returns 0xDEADBEEF after 1 busy cycle -> oLDST_MASK=4'b1111, oLDST_ADDR=0x0000_1004, oWB_DATA=0xDEADBEEF, oWB_WE=1.
- Signed byte load addr 0x0000_2003, response 0x1122_3380 -> mask 4'b0001, oWB_DATA=0xFFFF_FF80; unsigned -> 0x0000_0080.
- Half store 0xABCD to 0x0000_3002 -> oLDST_DATA=0xABCD_ABCD, mask 4'b0011, RW=1; oWB_VALID after iLDST_VALID with oWB_WE=0.
- Word load addr 0x0000_4002 -> no oLDST_REQ, oWB_VALID cycle 1 with oWB_FAULT=1, oWB_WE=0.
- iLDST_BUSY held 5 cycles then iWB_BUSY held 3 cycles -> oLDST_* and oWB_* stable throughout, single request issued.
- iRESET_SYNC in WAIT, then stray iLDST_VALID -> state IDLE, oWB_VALID never asserts, next op completes normally.
